// File: rtl/inst_encoder_if.sv
// Request/response bundle between an instruction producer and inst_encoder.
// Handshake: a side transfers on a rising edge where valid && ready. valid
// never waits on ready, and neither ready output depends on its valid.
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32 instruction encoder feeding a FIFO_DEPTH-entry output buffer with saturating statistics.
// Optional macro IMM_RANGE_CHECK_EN flags immediates that do not fit their instruction field.
module inst_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    inst_encoder_if.slave    bus,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic imm_ok12;
    logic imm_ok20;

`ifdef IMM_RANGE_CHECK_EN
    // A signed value fits N bits when every bit from N-1 upward equals the sign.
    assign imm_ok12 = (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);
    assign imm_ok20 = (&bus.in_imm[31:19]) | ~(|bus.in_imm[31:19]);
`else
    assign imm_ok12 = 1'b1;
    assign imm_ok20 = 1'b1;
`endif

    logic [31:0] enc_inst;
    logic        enc_err;

    always_comb begin
        enc_inst = {25'b0, bus.in_opcode};
        enc_err  = 1'b0;
        case (bus.in_opcode)
            OP_IMM, OP_LOAD, OP_JALR: begin
                enc_inst = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                enc_err  = !imm_ok12;
            end
            OP_STORE: begin
                enc_inst = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_imm[4:0], bus.in_opcode};
                enc_err  = !imm_ok12;
            end
            // B and J immediates arrive in halfwords, so bit k here is address bit k+1.
            OP_BRANCH: begin
                enc_inst = {bus.in_imm[11], bus.in_imm[9:4], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_imm[3:0], bus.in_imm[10], bus.in_opcode};
                enc_err  = !imm_ok12;
            end
            OP_JAL: begin
                enc_inst = {bus.in_imm[19], bus.in_imm[9:0], bus.in_imm[10], bus.in_imm[18:11],
                            bus.in_rd, bus.in_opcode};
                enc_err  = !imm_ok20;
            end
            OP_REG: begin
                enc_inst = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            end
            default: enc_err = 1'b1;
        endcase
    end

    logic [31:0]      inst_mem_q [FIFO_DEPTH];
    logic             err_mem_q  [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             rdy_q;
    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             full, empty, push, pop;

    // Pointers carry one extra lap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign bus.in_ready  = rdy_q && !full;
    assign bus.out_valid = !empty;
    assign bus.out_inst  = empty ? 32'd0 : inst_mem_q[rd_ptr_q[AW-1:0]];
    assign bus.out_err   = !empty && err_mem_q[rd_ptr_q[AW-1:0]];

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
        enc_cnt_d = enc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (push && (enc_cnt_q != {CNT_W{1'b1}})) enc_cnt_d = enc_cnt_q + CNT_ONE;
        if (push && enc_err && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rdy_q     <= 1'b0;
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rdy_q     <= 1'b1;
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible between matching pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q[AW-1:0]] <= enc_inst;
            err_mem_q[wr_ptr_q[AW-1:0]]  <= enc_err;
        end
    end

    assign enc_cnt = enc_cnt_q;
    assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed cases, then random traffic scored
// against a queue model; honours IMM_RANGE_CHECK_EN when defined for the build.
`timescale 1ns/1ps
module tb_inst_encoder;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] enc_cnt, err_cnt;

    inst_encoder_if bus();

    inst_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_imm_op(input logic [6:0] op);
        return op inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F};
    endfunction

    function automatic bit imm_fits(input logic [6:0] op, input logic [31:0] imm);
        int v;
        v = imm;
        if (op == 7'h6F) return (v >= -(1 << 19)) && (v <= (1 << 19) - 1);
        return (v >= -2048) && (v <= 2047);
    endfunction

    function automatic logic [32:0] model_encode(input logic [6:0] op, input logic [4:0] rd,
                                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                                 input logic [2:0] f3, input logic [6:0] f7,
                                                 input logic [31:0] imm);
        logic [31:0] w;
        logic        err;
        err = 1'b0;
        case (op)
            7'h13, 7'h03, 7'h67: w = {imm[11:0], rs1, f3, rd, op};
            7'h23: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            7'h63: w = {imm[11], imm[9:4], rs2, rs1, f3, imm[3:0], imm[10], op};
            7'h6F: w = {imm[19], imm[9:0], imm[10], imm[18:11], rd, op};
            7'h33: w = {f7, rs2, rs1, f3, rd, op};
            default: begin
                w   = {25'b0, op};
                err = 1'b1;
            end
        endcase
        if (RC && is_imm_op(op) && !imm_fits(op, imm)) err = 1'b1;
        return {err, w};
    endfunction

    // Standard RV32 immediate decoder; B and J results are in halfwords.
    function automatic logic [31:0] decode_imm(input logic [31:0] w);
        case (w[6:0])
            7'h23:   return {{20{w[31]}}, w[31:25], w[11:7]};
            7'h63:   return {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
            7'h6F:   return {{12{w[31]}}, w[31], w[19:12], w[20], w[30:21]};
            default: return {{20{w[31]}}, w[31:20]};
        endcase
    endfunction

    // Entry layout: {chk, err, imm, inst}.
    logic [65:0] exp_q[$];
    bit          mdl_rdy = 1'b0;
    int          mdl_enc = 0;
    int          mdl_err = 0;

    always @(posedge clk or negedge rst_n) begin
        bit          push, pop, chk;
        logic [32:0] r;
        if (!rst_n) begin
            exp_q.delete();
            mdl_rdy = 1'b0;
            mdl_enc = 0;
            mdl_err = 0;
        end else begin
            push = bus.in_valid && mdl_rdy && (exp_q.size() < DEPTH);
            pop  = bus.out_ready && (exp_q.size() > 0);
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                r   = model_encode(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                                   bus.in_funct3, bus.in_funct7, bus.in_imm);
                chk = is_imm_op(bus.in_opcode) && imm_fits(bus.in_opcode, bus.in_imm);
                exp_q.push_back({chk, r[32], bus.in_imm, r[31:0]});
                if (mdl_enc < CMAX) mdl_enc++;
                if (r[32] && mdl_err < CMAX) mdl_err++;
            end
            mdl_rdy = 1'b1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [65:0] h;
        check("in_ready", {31'b0, bus.in_ready}, {31'b0, mdl_rdy && (exp_q.size() < DEPTH)});
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check("out_inst", bus.out_inst, h[31:0]);
            check("out_err", {31'b0, bus.out_err}, {31'b0, h[64]});
            if (h[65]) check("decoded_imm", decode_imm(bus.out_inst), h[63:32]);
        end else begin
            check("idle_inst", bus.out_inst, 32'd0);
            check("idle_err", {31'b0, bus.out_err}, 32'd0);
        end
        check("enc_cnt", {28'b0, enc_cnt}, mdl_enc);
        check("err_cnt", {28'b0, err_cnt}, mdl_err);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
        bus.in_valid  = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        int n;
        drive(op, rd, rs1, rs2, f3, f7, imm);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            miscompares++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] bad_ops [5];
        bad_ops = '{7'h37, 7'h17, 7'h0F, 7'h73, 7'h00};

        drive(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_out_inst", bus.out_inst, 32'd0);
        check("rst_enc_cnt", {28'b0, enc_cnt}, 32'd0);
        rst_n = 1'b1;
        check("ready_before_edge", {31'b0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("ready_after_edge", {31'b0, bus.in_ready}, 32'd1);

        send(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        check("addi_inst", bus.out_inst, 32'hFFF1_0093);
        check("addi_err", {31'b0, bus.out_err}, 32'd0);
        check("addi_enc_cnt", {28'b0, enc_cnt}, 32'd1);

        send(7'h23, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd8);
        check("sw_inst", bus.out_inst, 32'h0051_2423);
        check("sw_err", {31'b0, bus.out_err}, 32'd0);

        send(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
        check("addi2048_field", {20'b0, bus.out_inst[31:20]}, 32'h800);
        check("addi2048_err", {31'b0, bus.out_err}, {31'b0, RC});
        check("addi2048_err_cnt", {28'b0, err_cnt}, {31'b0, RC});

        send(7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 32'd0);
        check("badop_inst", bus.out_inst, 32'h0000_007F);
        check("badop_err", {31'b0, bus.out_err}, 32'd1);
        @(negedge clk);

        // Backpressure: two words fill the buffer, the third must wait.
        bus.out_ready = 1'b0;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        repeat (3) @(negedge clk);
        check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("stall_head", bus.out_inst, 32'h0010_0093);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("after_pop_head", bus.out_inst, 32'h0020_0093);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        repeat (3) @(negedge clk);

        // Asynchronous reset with two words buffered.
        bus.out_ready = 1'b0;
        send(7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 32'd0);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("arst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("arst_enc_cnt", {28'b0, enc_cnt}, 32'd0);
        check("arst_err_cnt", {28'b0, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            int          k;
            logic [6:0]  op;
            logic [31:0] imm;
            k = $urandom_range(0, 9);
            case (k)
                0:       op = 7'h13;
                1:       op = 7'h03;
                2:       op = 7'h67;
                3:       op = 7'h23;
                4:       op = 7'h63;
                5:       op = 7'h6F;
                6:       op = 7'h33;
                7:       op = bad_ops[$urandom_range(0, 4)];
                default: op = 7'h13;
            endcase
            if (op == 7'h6F) imm = $urandom_range(0, (1 << 20) - 1) - (1 << 19);
            else             imm = $urandom_range(0, 4095) - 2048;
            if (k == 9) imm = $urandom();
            drive(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), imm);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("enc_saturated", {28'b0, enc_cnt}, CMAX);
        check("drained", {31'b0, bus.out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, output buffer entries (power of two, >=2).
REQ-002 Parameter: CNT_W, default 16, width of statistics counters.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  encode request present.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Ports: in_opcode[6:0], in_rd[4:0], in_rs1[4:0], in_rs2[4:0], in_funct3[2:0], in_funct7[6:0]  inputs  instruction fields.
REQ-008 Port: in_imm  input  32  signed immediate, in the same units the immediate decoder produces (B and J in halfwords).
REQ-009 Port: out_valid  output  1  encoded word available.
REQ-010 Port: out_ready  input  1  consumer takes the word.
REQ-011 Port: out_inst  output  32  encoded instruction.
REQ-012 Port: out_err  output  1  error flag travelling with out_inst.
REQ-013 Ports: enc_cnt, err_cnt  outputs  CNT_W  accepted-request and error counts.

Function
REQ-014 Transfer occurs on the input side when in_valid&&in_ready and on the output side when out_valid&&out_ready.
REQ-015 Encoding classes: I = 0010011/0000011/1100111 -> {imm[11:0],rs1,funct3,rd,op}; S = 0100011 -> {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
REQ-016 B = 1100011 -> {imm[11],imm[9:4],rs2,rs1,funct3,imm[3:0],imm[10],op}; J = 1101111 -> {imm[19],imm[9:0],imm[10],imm[18:11],rd,op}.
REQ-017 R = 0110011 -> {funct7,rs2,rs1,funct3,rd,op}; in_imm is ignored.
REQ-018 Any other opcode -> out_inst = {25'b0,opcode}, with the error flag set.
REQ-019 Encoded word plus flag are written into a FIFO of FIFO_DEPTH entries; out_inst/out_err/out_valid are driven from the FIFO head.
REQ-020 Latency: a request accepted at edge N is visible on out_valid after edge N (one cycle); no combinational in->out path.
REQ-021 in_ready = FIFO not full; out_valid = FIFO not empty.
REQ-022 When full, in_ready=0 even if out_ready=1 in the same cycle (no pass-through).
REQ-023 Simultaneous push and pop while non-full and non-empty: occupancy unchanged, order preserved.
REQ-024 Read and write pointers wrap modulo FIFO_DEPTH; strict FIFO order.
REQ-025 out_inst and out_err hold stable while out_valid=1 and out_ready=0.
REQ-026 enc_cnt increments on each input transfer; err_cnt increments on each input transfer whose flag is set; both saturate at 2^CNT_W-1.

Reset
REQ-027 rst_n low asynchronously empties the FIFO and clears both counters; out_valid=0, out_inst=0, out_err=0, in_ready=0 while held.
REQ-028 in_ready rises on the first edge after rst_n deasserts; reset mid-transfer discards all buffered words.

Configuration
REQ-029 Macro IMM_RANGE_CHECK_EN defined: out_err also set when in_imm does not fit its field (I/S/B signed 12-bit -2048..2047, J signed 20-bit); the word is still encoded from the truncated bits.
REQ-030 Macro undefined: no range check; immediates silently truncated; out_err set only for unsupported opcodes.

Verification
REQ-031 addi rd=1,rs1=2,f3=0,imm=0xFFFFFFFF -> out_inst=0xFFF10093, out_err=0, one cycle later, enc_cnt=1.
REQ-032 sw rs2=5,rs1=2,f3=010,imm=8 -> out_inst=0x00512423, out_err=0.
REQ-033 addi imm=2048 -> with macro out_err=1, err_cnt=1; without macro out_err=0, out_inst[31:20]=0x800.
REQ-034 out_ready=0, 3 back-to-back requests, FIFO_DEPTH=2 -> in_ready low after 2nd; release out_ready -> 3 words out in order.
REQ-035 Random I/S/B/J in range, decoded by the immediate decoder -> decoded imm equals in_imm for every word.
REQ-036 rst_n pulsed low with 2 words buffered -> out_valid=0 immediately, counters 0, no stale word after reset.
